// File: rtl/bster_cmd_frontend_if.sv
// Command, engine request/response, completion and status channels of the BST command front-end.
interface bster_cmd_frontend_if #(
    parameter int unsigned CMD_WIDTH = 128,
    parameter int unsigned STS_WIDTH = 8,
    parameter int unsigned KEY_WIDTH = 32,
    parameter int unsigned VAL_WIDTH = 32
);
    // command stream
    logic                 cmd_tvalid;
    logic                 cmd_tready;
    logic [CMD_WIDTH-1:0] cmd_tdata;
    // engine request
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [KEY_WIDTH-1:0] req_key;
    logic [VAL_WIDTH-1:0] req_value;
    // engine response
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_found;
    logic                 rsp_error;
    logic [VAL_WIDTH-1:0] rsp_value;
    // completion stream
    logic                 cpl_tvalid;
    logic                 cpl_tready;
    logic [CMD_WIDTH-1:0] cpl_tdata;
    // status stream
    logic                 sts_tvalid;
    logic                 sts_tready;
    logic [STS_WIDTH-1:0] sts_tdata;

    // front-end side
    modport master (
        input  cmd_tvalid, cmd_tdata,
        output cmd_tready,
        output req_valid, req_op, req_key, req_value,
        input  req_ready,
        input  rsp_valid, rsp_found, rsp_error, rsp_value,
        output rsp_ready,
        output cpl_tvalid, cpl_tdata,
        input  cpl_tready,
        output sts_tvalid, sts_tdata,
        input  sts_tready
    );

    // environment side (command source, engine, completion/status sinks)
    modport slave (
        output cmd_tvalid, cmd_tdata,
        input  cmd_tready,
        input  req_valid, req_op, req_key, req_value,
        output req_ready,
        output rsp_valid, rsp_found, rsp_error, rsp_value,
        input  rsp_ready,
        input  cpl_tvalid, cpl_tdata,
        output cpl_tready,
        input  sts_tvalid, sts_tdata,
        output sts_tready
    );
endinterface

// File: rtl/bster_cmd_frontend.sv
// BST command front-end: decodes stream commands, dispatches one at a time to the
// tree engine, and returns one completion beat plus one status beat per command.
module bster_cmd_frontend #(
    parameter int unsigned CMD_WIDTH = 128,
    parameter int unsigned STS_WIDTH = 8,
    parameter int unsigned KEY_WIDTH = 32,
    parameter int unsigned VAL_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    bster_cmd_frontend_if.master bus
);
    localparam int unsigned KEY_LSB = 8;
    localparam int unsigned VAL_LSB = KEY_LSB + KEY_WIDTH;
    localparam int unsigned PAY_MSB = VAL_LSB + VAL_WIDTH - 1;

    localparam logic [7:0] OP_INSERT = 8'h01;
    localparam logic [7:0] OP_SEARCH = 8'h02;
    localparam logic [7:0] OP_DELETE = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT_RSP,
        SEND
    } state_t;

    state_t               state_q,      state_d;
    logic                 cmd_tready_q, cmd_tready_d;
    logic                 req_valid_q,  req_valid_d;
    logic [1:0]           req_op_q,     req_op_d;
    logic [KEY_WIDTH-1:0] req_key_q,    req_key_d;
    logic [VAL_WIDTH-1:0] req_value_q,  req_value_d;
    logic                 rsp_ready_q,  rsp_ready_d;
    logic                 cpl_tvalid_q, cpl_tvalid_d;
    logic [CMD_WIDTH-1:0] cpl_tdata_q,  cpl_tdata_d;
    logic                 sts_tvalid_q, sts_tvalid_d;
    logic [STS_WIDTH-1:0] sts_tdata_q,  sts_tdata_d;
    logic [7:0]           op_q,         op_d;
    logic [3:0]           tag_q,        tag_d;

    logic [7:0]           cmd_op;
    logic [KEY_WIDTH-1:0] cmd_key;
    logic [VAL_WIDTH-1:0] cmd_val;
    logic                 cmd_op_ok;
    logic [3:0]           sts_flags;
    logic [VAL_WIDTH-1:0] cpl_val;

    // Command field decode
    assign cmd_op    = bus.cmd_tdata[7:0];
    assign cmd_key   = bus.cmd_tdata[VAL_LSB-1:KEY_LSB];
    assign cmd_val   = bus.cmd_tdata[PAY_MSB:VAL_LSB];
    assign cmd_op_ok = (cmd_op == OP_INSERT) || (cmd_op == OP_SEARCH) || (cmd_op == OP_DELETE);

    // Command bits above the value field carry no meaning
    if (CMD_WIDTH > PAY_MSB + 1) begin : g_unused_cmd
        logic unused_cmd_bits;
        assign unused_cmd_bits = ^bus.cmd_tdata[CMD_WIDTH-1:PAY_MSB+1];
    end

    // Completion word: opcode echo, key echo, value field, remaining bits zero
    function automatic logic [CMD_WIDTH-1:0] cpl_word(input logic [7:0]           op,
                                                      input logic [KEY_WIDTH-1:0] key,
                                                      input logic [VAL_WIDTH-1:0] val);
        logic [CMD_WIDTH-1:0] w;
        w                      = '0;
        w[7:0]                 = op;
        w[VAL_LSB-1:KEY_LSB]   = key;
        w[PAY_MSB:VAL_LSB]     = val;
        return w;
    endfunction

    // Status word: flag nibble and sequence tag, remaining bits zero
    function automatic logic [STS_WIDTH-1:0] sts_word(input logic [3:0] flags,
                                                      input logic [3:0] tag);
        logic [STS_WIDTH-1:0] w;
        w      = '0;
        w[3:0] = flags;
        w[7:4] = tag;
        return w;
    endfunction

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_op_d     = req_op_q;
        req_key_d    = req_key_q;
        req_value_d  = req_value_q;
        cpl_tvalid_d = cpl_tvalid_q;
        cpl_tdata_d  = cpl_tdata_q;
        sts_tvalid_d = sts_tvalid_q;
        sts_tdata_d  = sts_tdata_q;
        op_d         = op_q;
        tag_d        = tag_q;
        sts_flags    = 4'b0001;
        cpl_val      = '0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_tvalid && cmd_tready_q) begin
                    op_d = cmd_op;
                    if (cmd_op_ok) begin
                        state_d     = DISPATCH;
                        req_valid_d = 1'b1;
                        req_op_d    = cmd_op[1:0];
                        req_key_d   = cmd_key;
                        req_value_d = cmd_val;
                    end else begin
                        // unknown opcode is answered locally, the engine never sees it
                        state_d      = SEND;
                        cpl_tvalid_d = 1'b1;
                        sts_tvalid_d = 1'b1;
                        cpl_tdata_d  = cpl_word(cmd_op, cmd_key, '0);
                        sts_tdata_d  = sts_word(4'b0100, tag_q);
                    end
                end
            end
            DISPATCH: begin
                if (bus.req_ready) begin
                    state_d     = WAIT_RSP;
                    req_valid_d = 1'b0;
                end
            end
            WAIT_RSP: begin
                if (bus.rsp_valid && rsp_ready_q) begin
                    if (bus.rsp_error) begin
                        sts_flags = 4'b1000;
                    end else if (((op_q == OP_SEARCH) || (op_q == OP_DELETE)) && !bus.rsp_found) begin
                        sts_flags = 4'b0010;
                    end else begin
                        sts_flags = 4'b0001;
                        if (op_q == OP_SEARCH) begin
                            cpl_val = bus.rsp_value;
                        end
                    end
                    state_d      = SEND;
                    cpl_tvalid_d = 1'b1;
                    sts_tvalid_d = 1'b1;
                    cpl_tdata_d  = cpl_word(op_q, req_key_q, cpl_val);
                    sts_tdata_d  = sts_word(sts_flags, tag_q);
                end
            end
            SEND: begin
                // each stream retires on its own handshake
                cpl_tvalid_d = cpl_tvalid_q && !bus.cpl_tready;
                sts_tvalid_d = sts_tvalid_q && !bus.sts_tready;
                if (!cpl_tvalid_d && !sts_tvalid_d) begin
                    state_d = IDLE;
                    tag_d   = tag_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_tready_d = (state_d == IDLE);
        rsp_ready_d  = (state_d == WAIT_RSP);
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            cmd_tready_q <= 1'b0;
            req_valid_q  <= 1'b0;
            req_op_q     <= '0;
            req_key_q    <= '0;
            req_value_q  <= '0;
            rsp_ready_q  <= 1'b0;
            cpl_tvalid_q <= 1'b0;
            cpl_tdata_q  <= '0;
            sts_tvalid_q <= 1'b0;
            sts_tdata_q  <= '0;
            op_q         <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_tready_q <= cmd_tready_d;
            req_valid_q  <= req_valid_d;
            req_op_q     <= req_op_d;
            req_key_q    <= req_key_d;
            req_value_q  <= req_value_d;
            rsp_ready_q  <= rsp_ready_d;
            cpl_tvalid_q <= cpl_tvalid_d;
            cpl_tdata_q  <= cpl_tdata_d;
            sts_tvalid_q <= sts_tvalid_d;
            sts_tdata_q  <= sts_tdata_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
        end
    end

    assign bus.cmd_tready = cmd_tready_q;
    assign bus.req_valid  = req_valid_q;
    assign bus.req_op     = req_op_q;
    assign bus.req_key    = req_key_q;
    assign bus.req_value  = req_value_q;
    assign bus.rsp_ready  = rsp_ready_q;
    assign bus.cpl_tvalid = cpl_tvalid_q;
    assign bus.cpl_tdata  = cpl_tdata_q;
    assign bus.sts_tvalid = sts_tvalid_q;
    assign bus.sts_tdata  = sts_tdata_q;

endmodule

// File: tb/tb_bster_cmd_frontend.sv
// Scoreboard bench for bster_cmd_frontend: command source, engine model and
// completion/status sinks all stepped once per cycle on the falling edge.
module tb_bster_cmd_frontend;
    localparam int unsigned CMD_WIDTH = 128;
    localparam int unsigned STS_WIDTH = 8;
    localparam int unsigned KEY_WIDTH = 32;
    localparam int unsigned VAL_WIDTH = 32;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    bster_cmd_frontend_if #(
        .CMD_WIDTH(CMD_WIDTH), .STS_WIDTH(STS_WIDTH),
        .KEY_WIDTH(KEY_WIDTH), .VAL_WIDTH(VAL_WIDTH)
    ) bus ();

    bster_cmd_frontend #(
        .CMD_WIDTH(CMD_WIDTH), .STS_WIDTH(STS_WIDTH),
        .KEY_WIDTH(KEY_WIDTH), .VAL_WIDTH(VAL_WIDTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] key;
        logic [31:0] val;
        logic [31:0] rval;
        logic        found;
        logic        err;
        int          delay;     // engine response delay, -1 = random
        int          cpl_hold;  // cycles to hold cpl_tready low
    } cmd_t;

    cmd_t         stim_q[$];
    cmd_t         eng_q[$];
    logic [127:0] exp_cpl_q[$];
    logic [7:0]   exp_sts_q[$];
    cmd_t         cur_cmd;
    cmd_t         rsp_cmd;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_cpl = 0;
    int         n_sts = 0;
    logic [3:0] tag_m = 4'd0;
    bit         bp = 1'b0;
    bit         hs_cmd, hs_req, hs_rsp, hs_cpl, hs_sts;
    bit         due_req, due_out, due_idle;
    bit         outstanding, cpl_done, sts_done, rsp_pending;
    int         rsp_delay, cpl_hold_cnt;
    bit         prev_req_wait, prev_cpl_wait, prev_sts_wait;
    logic [65:0]  prev_req;
    logic [127:0] prev_cpl;
    logic [7:0]   prev_sts;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour: completion and status words for one command
    function automatic void model(input cmd_t c, input logic [3:0] t,
                                  output logic [127:0] cpl, output logic [7:0] sts);
        cpl        = '0;
        cpl[7:0]   = c.op;
        cpl[39:8]  = c.key;
        sts        = '0;
        sts[7:4]   = t;
        if (!(c.op inside {8'h01, 8'h02, 8'h03})) sts[2] = 1'b1;
        else if (c.err)                             sts[3] = 1'b1;
        else if ((c.op != 8'h01) && !c.found)       sts[1] = 1'b1;
        else begin
            sts[0] = 1'b1;
            if (c.op == 8'h02) cpl[71:40] = c.rval;
        end
    endfunction

    function automatic cmd_t mk(input logic [7:0] op, input logic [31:0] key, input logic [31:0] val,
                                input logic found, input logic err, input logic [31:0] rval,
                                input int delay, input int hold);
        cmd_t c;
        c.op = op; c.key = key; c.val = val; c.found = found; c.err = err;
        c.rval = rval; c.delay = delay; c.cpl_hold = hold;
        return c;
    endfunction

    function automatic logic rnd_ready();
        return bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // One clock of environment activity, evaluated between rising edges
    task automatic tick();
        logic [63:0]  junk;
        logic [127:0] ec;
        logic [7:0]   es;
        cmd_t         e;
        @(negedge aclk);
        if (hs_cmd) bus.cmd_tvalid = 1'b0;
        if (hs_rsp) begin
            bus.rsp_valid = 1'b0;
            rsp_pending   = 1'b0;
        end

        if (due_req) check_val("req_latency", 128'(bus.req_valid), 128'(1));
        if (due_out) begin
            check_val("cpl_latency", 128'(bus.cpl_tvalid), 128'(1));
            check_val("sts_latency", 128'(bus.sts_tvalid), 128'(1));
        end
        if (due_idle)         check_val("idle_ready", 128'(bus.cmd_tready), 128'(1));
        else if (outstanding) check_val("busy_ready", 128'(bus.cmd_tready), 128'(0));
        if (prev_req_wait) begin
            check_val("req_hold_valid", 128'(bus.req_valid), 128'(1));
            check_val("req_hold_data", 128'({bus.req_op, bus.req_key, bus.req_value}), 128'(prev_req));
        end
        if (prev_cpl_wait) begin
            check_val("cpl_hold_valid", 128'(bus.cpl_tvalid), 128'(1));
            check_val("cpl_hold_data", bus.cpl_tdata, prev_cpl);
        end
        if (prev_sts_wait) begin
            check_val("sts_hold_valid", 128'(bus.sts_tvalid), 128'(1));
            check_val("sts_hold_data", 128'(bus.sts_tdata), 128'(prev_sts));
        end
        due_req = 1'b0; due_out = 1'b0; due_idle = 1'b0;

        // engine model
        if (rsp_pending && !bus.rsp_valid) begin
            if (rsp_delay == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_found = rsp_cmd.found;
                bus.rsp_error = rsp_cmd.err;
                bus.rsp_value = rsp_cmd.rval;
            end else begin
                rsp_delay--;
            end
        end

        // command source; bits above the value field get random filler
        if (!bus.cmd_tvalid && stim_q.size() > 0 && (!bp || $urandom_range(0, 3) != 0)) begin
            cur_cmd        = stim_q.pop_front();
            junk           = {$urandom(), $urandom()};
            bus.cmd_tdata  = {junk[55:0], cur_cmd.val, cur_cmd.key, cur_cmd.op};
            bus.cmd_tvalid = 1'b1;
        end

        bus.req_ready  = rnd_ready();
        bus.sts_tready = rnd_ready();
        if (bus.cpl_tvalid && cpl_hold_cnt > 0) begin
            bus.cpl_tready = 1'b0;
            cpl_hold_cnt--;
        end else begin
            bus.cpl_tready = rnd_ready();
        end

        // handshakes that will complete on the coming rising edge
        hs_cmd = bus.cmd_tvalid && bus.cmd_tready;
        hs_req = bus.req_valid  && bus.req_ready;
        hs_rsp = bus.rsp_valid  && bus.rsp_ready;
        hs_cpl = bus.cpl_tvalid && bus.cpl_tready;
        hs_sts = bus.sts_tvalid && bus.sts_tready;

        if (hs_cmd) begin
            model(cur_cmd, tag_m, ec, es);
            exp_cpl_q.push_back(ec);
            exp_sts_q.push_back(es);
            tag_m        = tag_m + 4'd1;
            outstanding  = 1'b1;
            cpl_done     = 1'b0;
            sts_done     = 1'b0;
            cpl_hold_cnt = cur_cmd.cpl_hold;
            if (cur_cmd.op inside {8'h01, 8'h02, 8'h03}) begin
                eng_q.push_back(cur_cmd);
                due_req = 1'b1;
            end else begin
                due_out = 1'b1;
            end
        end
        if (hs_req) begin
            if (eng_q.size() == 0) begin
                check_val("req_spurious", 128'(bus.req_valid), 128'(0));
            end else begin
                e = eng_q.pop_front();
                check_val("req_op", 128'(bus.req_op), 128'(e.op[1:0]));
                check_val("req_key", 128'(bus.req_key), 128'(e.key));
                check_val("req_value", 128'(bus.req_value), 128'(e.val));
                rsp_cmd     = e;
                rsp_pending = 1'b1;
                rsp_delay   = (e.delay >= 0) ? e.delay : (bp ? int'($urandom_range(0, 3)) : 0);
            end
        end
        if (hs_rsp) due_out = 1'b1;
        if (hs_cpl) begin
            if (exp_cpl_q.size() == 0) check_val("cpl_spurious", 128'(bus.cpl_tvalid), 128'(0));
            else                       check_val("cpl_data", bus.cpl_tdata, exp_cpl_q.pop_front());
            n_cpl++;
            cpl_done = 1'b1;
        end
        if (hs_sts) begin
            if (exp_sts_q.size() == 0) check_val("sts_spurious", 128'(bus.sts_tvalid), 128'(0));
            else                       check_val("sts_data", 128'(bus.sts_tdata), 128'(exp_sts_q.pop_front()));
            n_sts++;
            sts_done = 1'b1;
        end
        if (outstanding && cpl_done && sts_done) begin
            outstanding = 1'b0;
            due_idle    = 1'b1;
        end

        prev_req_wait = bus.req_valid && !hs_req;
        prev_req      = {bus.req_op, bus.req_key, bus.req_value};
        prev_cpl_wait = bus.cpl_tvalid && !hs_cpl;
        prev_cpl      = bus.cpl_tdata;
        prev_sts_wait = bus.sts_tvalid && !hs_sts;
        prev_sts      = bus.sts_tdata;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((stim_q.size() != 0 || bus.cmd_tvalid || outstanding) && n < budget) begin
            tick();
            n++;
        end
        check_val("drain_done", 128'((stim_q.size() != 0) || outstanding), 128'(0));
        tick();
    endtask

    // Asynchronous reset pulse: outputs must clear without a clock edge
    task automatic do_reset();
        #2 aresetn = 1'b0;
        #1;
        check_val("rst_cmd_tready", 128'(bus.cmd_tready), 128'(0));
        check_val("rst_req_valid", 128'(bus.req_valid), 128'(0));
        check_val("rst_rsp_ready", 128'(bus.rsp_ready), 128'(0));
        check_val("rst_cpl_tvalid", 128'(bus.cpl_tvalid), 128'(0));
        check_val("rst_sts_tvalid", 128'(bus.sts_tvalid), 128'(0));
        check_val("rst_cpl_tdata", bus.cpl_tdata, 128'(0));
        check_val("rst_sts_tdata", 128'(bus.sts_tdata), 128'(0));
        check_val("rst_req_key", 128'(bus.req_key), 128'(0));
        stim_q.delete(); eng_q.delete(); exp_cpl_q.delete(); exp_sts_q.delete();
        bus.cmd_tvalid = 1'b0;
        bus.rsp_valid  = 1'b0;
        hs_cmd = 1'b0; hs_req = 1'b0; hs_rsp = 1'b0; hs_cpl = 1'b0; hs_sts = 1'b0;
        due_req = 1'b0; due_out = 1'b0;
        outstanding = 1'b0; rsp_pending = 1'b0; cpl_hold_cnt = 0;
        prev_req_wait = 1'b0; prev_cpl_wait = 1'b0; prev_sts_wait = 1'b0;
        tag_m = 4'd0;
        repeat (2) @(negedge aclk);
        aresetn  = 1'b1;
        due_idle = 1'b1;
    endtask

    initial begin
        int n;
        aresetn        = 1'b1;
        bus.cmd_tvalid = 1'b0;
        bus.cmd_tdata  = '0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_found  = 1'b0;
        bus.rsp_error  = 1'b0;
        bus.rsp_value  = '0;
        bus.cpl_tready = 1'b0;
        bus.sts_tready = 1'b0;
        do_reset();

        // directed cases, no backpressure
        bp = 1'b0;
        stim_q.push_back(mk(8'h02, 32'h10, 32'h0, 1'b1, 1'b0, 32'hCAFE, -1, 0));
        stim_q.push_back(mk(8'h7F, 32'h55, 32'h1234, 1'b0, 1'b0, 32'h0, -1, 0));
        stim_q.push_back(mk(8'h03, 32'h20, 32'h0, 1'b0, 1'b0, 32'hDEAD, -1, 5));
        stim_q.push_back(mk(8'h01, 32'h30, 32'h99, 1'b0, 1'b1, 32'hBEEF, -1, 0));
        stim_q.push_back(mk(8'h01, 32'h30, 32'h77, 1'b1, 1'b0, 32'h1111, 2, 0));
        stim_q.push_back(mk(8'h02, 32'h44, 32'h0, 1'b0, 1'b0, 32'h2222, 1, 0));
        run_until_idle(300);
        check_val("directed_cpl_count", 128'(n_cpl), 128'(6));
        check_val("directed_sts_count", 128'(n_sts), 128'(6));

        // 17 back-to-back commands under random backpressure, tags 0..15,0
        do_reset();
        bp    = 1'b1;
        n_cpl = 0;
        n_sts = 0;
        for (int i = 0; i < 17; i++) begin
            stim_q.push_back(mk(8'($urandom_range(1, 3)), $urandom(), $urandom(),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                                $urandom(), -1, 0));
        end
        run_until_idle(3000);
        check_val("bb_cpl_count", 128'(n_cpl), 128'(17));
        check_val("bb_sts_count", 128'(n_sts), 128'(17));
        check_val("bb_tag_model", 128'(tag_m), 128'(1));

        // reset while the engine holds the response
        bp = 1'b0;
        stim_q.push_back(mk(8'h02, 32'h66, 32'h0, 1'b1, 1'b0, 32'h5A5A, 40, 0));
        n = 0;
        while (!(rsp_pending && bus.rsp_ready) && n < 50) begin
            tick();
            n++;
        end
        check_val("reach_wait_rsp", 128'(bus.rsp_ready), 128'(1));
        do_reset();
        n_cpl = 0;
        n_sts = 0;
        repeat (5) tick();
        check_val("post_rst_no_cpl", 128'(n_cpl), 128'(0));
        check_val("post_rst_no_sts", 128'(n_sts), 128'(0));
        stim_q.push_back(mk(8'h02, 32'h10, 32'h0, 1'b1, 1'b0, 32'hCAFE, -1, 0));
        run_until_idle(300);
        check_val("post_rst_cpl_count", 128'(n_cpl), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
